// File: rtl/snax_csr_wide_bridge.sv
// Bridge between the 32-bit SNAX accelerator channel and a wide CSR bus:
// packs write beats into one CSR word and serializes wide read data back.
module snax_csr_wide_bridge #(
  parameter int unsigned CsrDataWidth  = 64,
  parameter logic [31:0] CsrAddrOffset = 32'h3c0,
  parameter int unsigned IdWidth       = 5,
  parameter int unsigned RdFifoDepth   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    snax_qvalid_i,
  output logic                    snax_qready_o,
  input  logic                    snax_q_write_i,
  input  logic [31:0]             snax_q_data_i,
  input  logic [31:0]             snax_q_addr_i,
  input  logic [IdWidth-1:0]      snax_q_id_i,
  output logic                    snax_pvalid_o,
  input  logic                    snax_pready_i,
  output logic [31:0]             snax_p_data_o,
  output logic [IdWidth-1:0]      snax_p_id_o,
  output logic                    snax_p_error_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  output logic                    csr_req_write_o,
  output logic [31:0]             csr_req_addr_o,
  output logic [CsrDataWidth-1:0] csr_req_data_o,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,
  input  logic [CsrDataWidth-1:0] csr_rsp_data_i,
  output logic                    err_pulse_o
);

  localparam int unsigned NumBeats = CsrDataWidth / 32;
  localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned IdxW     = (RdFifoDepth > 1) ? $clog2(RdFifoDepth) : 1;
  localparam int unsigned PtrW     = $clog2(RdFifoDepth) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_e;

  state_e                       state_q, state_d;
  logic [CntW-1:0]              cnt_q;
  logic [31:0]                  addr_q;
  logic [NumBeats-1:0][31:0]    lane_q;
  logic [NumBeats-1:0][31:0]    wdata;

  logic [IdWidth-1:0]           fifo_mem [2**IdxW];
  logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q, fifo_cnt;
  logic                         fifo_full, fifo_empty;

  logic                         ser_full_q;
  logic [CntW-1:0]              ser_lane_q;
  logic [CsrDataWidth-1:0]      ser_data_q;
  logic [IdWidth-1:0]           ser_id_q;

  logic                         partial, addr_mismatch, final_beat, discard;
  logic [CntW-1:0]              beat_idx;
  logic                         q_hs, push, pop, rsp_hs, p_hs, last_lane;

  // A write beat at a different address than the partial word restarts packing.
  assign partial       = (cnt_q != '0);
  assign addr_mismatch = snax_q_write_i && partial && (snax_q_addr_i != addr_q);
  assign beat_idx      = addr_mismatch ? '0 : cnt_q;
  assign final_beat    = (beat_idx == CntW'(NumBeats - 1));
  assign discard       = partial && (addr_mismatch || !snax_q_write_i);

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_cnt == PtrW'(RdFifoDepth));
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  always_comb begin
    snax_qready_o   = 1'b0;
    csr_req_valid_o = 1'b0;
    csr_req_write_o = 1'b0;
    csr_req_addr_o  = '0;
    wdata           = '0;
    if (snax_qvalid_i) begin
      if (snax_q_write_i && !final_beat) begin
        snax_qready_o = 1'b1;
      end else if (snax_q_write_i) begin
        csr_req_valid_o         = 1'b1;
        csr_req_write_o         = 1'b1;
        csr_req_addr_o          = snax_q_addr_i - CsrAddrOffset;
        wdata                   = lane_q;
        wdata[NumBeats-1]       = snax_q_data_i;
        snax_qready_o           = csr_req_ready_i;
      end else if (!fifo_full) begin
        csr_req_valid_o = 1'b1;
        csr_req_addr_o  = snax_q_addr_i - CsrAddrOffset;
        snax_qready_o   = csr_req_ready_i;
      end
    end
  end

  assign csr_req_data_o = wdata;
  assign q_hs           = snax_qvalid_i && snax_qready_o;
  assign err_pulse_o    = q_hs && discard;
  assign push           = q_hs && !snax_q_write_i;

  always_comb begin
    state_d = state_q;
    if (q_hs) begin
      state_d = (snax_q_write_i && !final_beat) ? COLLECT : IDLE;
    end else if (snax_qvalid_i) begin
      state_d = ISSUE;
    end else begin
      state_d = partial ? COLLECT : IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Write packing: lanes below the final one are buffered until the last beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      addr_q <= '0;
      lane_q <= '0;
    end else if (q_hs) begin
      if (snax_q_write_i && !final_beat) begin
        lane_q[beat_idx] <= snax_q_data_i;
        cnt_q            <= beat_idx + CntW'(1);
        if (beat_idx == '0) addr_q <= snax_q_addr_i;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Read-ID FIFO: the head stays valid until its last response lane is sent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[IdxW'(wr_ptr_q)] <= snax_q_id_i;
  end

  assign csr_rsp_ready_o = !ser_full_q && !fifo_empty;
  assign rsp_hs          = csr_rsp_valid_i && csr_rsp_ready_o;
  assign p_hs            = ser_full_q && snax_pready_i;
  assign last_lane       = (ser_lane_q == CntW'(NumBeats - 1));
  assign pop             = p_hs && last_lane;

  // Serializer: lane 0 sits in the low 32 bits and the word shifts down per beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ser_full_q <= 1'b0;
      ser_lane_q <= '0;
      ser_data_q <= '0;
      ser_id_q   <= '0;
    end else if (rsp_hs) begin
      ser_full_q <= 1'b1;
      ser_lane_q <= '0;
      ser_data_q <= csr_rsp_data_i;
      ser_id_q   <= fifo_mem[IdxW'(rd_ptr_q)];
    end else if (p_hs) begin
      ser_data_q <= ser_data_q >> 32;
      if (last_lane) ser_full_q <= 1'b0;
      else           ser_lane_q <= ser_lane_q + CntW'(1);
    end
  end

  assign snax_pvalid_o  = ser_full_q;
  assign snax_p_data_o  = ser_data_q[31:0];
  assign snax_p_id_o    = ser_id_q;
  assign snax_p_error_o = 1'b0;

  rsp_without_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
    csr_rsp_valid_i |-> !fifo_empty);

endmodule

// File: tb/tb_snax_csr_wide_bridge.sv
// Scoreboard bench for snax_csr_wide_bridge (64-bit CSR, two beats, depth-2 read FIFO).
module tb_snax_csr_wide_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        snax_qvalid_i = 1'b0, snax_q_write_i = 1'b0;
  logic [31:0] snax_q_data_i = '0, snax_q_addr_i = '0;
  logic [4:0]  snax_q_id_i = '0;
  logic        snax_qready_o, snax_pvalid_o, snax_p_error_o;
  logic        snax_pready_i = 1'b1;
  logic [31:0] snax_p_data_o;
  logic [4:0]  snax_p_id_o;
  logic        csr_req_valid_o, csr_req_write_o, csr_rsp_ready_o, err_pulse_o;
  logic        csr_req_ready_i = 1'b1, csr_rsp_valid_i = 1'b0;
  logic [31:0] csr_req_addr_o;
  logic [63:0] csr_req_data_o, csr_rsp_data_i = '0;

  always #5 clk_i = ~clk_i;

  snax_csr_wide_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .snax_qvalid_i(snax_qvalid_i), .snax_qready_o(snax_qready_o),
    .snax_q_write_i(snax_q_write_i), .snax_q_data_i(snax_q_data_i),
    .snax_q_addr_i(snax_q_addr_i), .snax_q_id_i(snax_q_id_i),
    .snax_pvalid_o(snax_pvalid_o), .snax_pready_i(snax_pready_i),
    .snax_p_data_o(snax_p_data_o), .snax_p_id_o(snax_p_id_o),
    .snax_p_error_o(snax_p_error_o),
    .csr_req_valid_o(csr_req_valid_o), .csr_req_ready_i(csr_req_ready_i),
    .csr_req_write_o(csr_req_write_o), .csr_req_addr_o(csr_req_addr_o),
    .csr_req_data_o(csr_req_data_o),
    .csr_rsp_valid_i(csr_rsp_valid_i), .csr_rsp_ready_o(csr_rsp_ready_o),
    .csr_rsp_data_i(csr_rsp_data_i), .err_pulse_o(err_pulse_o)
  );

  typedef struct packed {logic w; logic [31:0] addr; logic [63:0] data;} creq_t;
  typedef struct packed {logic [31:0] d; logic [4:0] id;} rsp_t;

  creq_t       exp_req_q[$];
  rsp_t        exp_rsp_q[$];
  logic [63:0] rd_plan_q[$];
  int checks = 0, errors = 0;
  int err_seen = 0, err_exp = 0, rd_pending = 0, rsp_seen = 0;
  bit rsp_hold = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // CSR request monitor with hold-stability check while stalled.
  initial begin
    bit rq_stall = 0;
    creq_t held, e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        rq_stall = 0;
        continue;
      end
      if (rq_stall) begin
        chk("req_hold_valid", csr_req_valid_o, 1);
        chk("req_hold_fields", {csr_req_write_o, csr_req_addr_o} ^ {held.w, held.addr}, 0);
        chk("req_hold_data", csr_req_data_o, held.data);
      end
      rq_stall = csr_req_valid_o && !csr_req_ready_i;
      held = '{csr_req_write_o, csr_req_addr_o, csr_req_data_o};
      if (csr_req_valid_o && csr_req_ready_i) begin
        if (exp_req_q.size() == 0) chk("req_unexpected", csr_req_addr_o, 64'hx);
        else begin
          e = exp_req_q.pop_front();
          chk("req_write", csr_req_write_o, e.w);
          chk("req_addr", csr_req_addr_o, e.addr);
          chk("req_data", csr_req_data_o, e.data);
        end
        if (!csr_req_write_o) rd_pending++;
      end
    end
  end

  // SNAX response monitor, hold check, and error-pulse counter.
  initial begin
    bit p_stall = 0;
    logic [31:0] pd;
    logic [4:0] pid;
    rsp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        p_stall = 0;
        continue;
      end
      if (err_pulse_o) err_seen++;
      if (p_stall) begin
        chk("rsp_hold_valid", snax_pvalid_o, 1);
        chk("rsp_hold_data", snax_p_data_o, pd);
        chk("rsp_hold_id", snax_p_id_o, pid);
      end
      p_stall = snax_pvalid_o && !snax_pready_i;
      pd = snax_p_data_o;
      pid = snax_p_id_o;
      if (snax_pvalid_o && snax_pready_i) begin
        rsp_seen++;
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", snax_p_data_o, 64'hx);
        else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_data", snax_p_data_o, e.d);
          chk("rsp_id", snax_p_id_o, e.id);
          chk("rsp_error", snax_p_error_o, 0);
        end
      end
    end
  end

  // CSR responder: returns planned read data, optionally held back.
  initial begin
    bit hs;
    forever begin
      @(negedge clk_i);
      hs = csr_rsp_valid_i && csr_rsp_ready_o;
      @(posedge clk_i);
      #1;
      if (hs || !rst_ni) csr_rsp_valid_i = 1'b0;
      if (!csr_rsp_valid_i && rst_ni && rd_pending > 0 && !rsp_hold && rd_plan_q.size() > 0) begin
        csr_rsp_valid_i = 1'b1;
        csr_rsp_data_i  = rd_plan_q.pop_front();
        rd_pending--;
      end
    end
  end

  task automatic req(input logic w, input logic [31:0] d, input logic [31:0] a, input logic [4:0] id);
    bit hs = 0;
    int cyc = 0;
    snax_qvalid_i = 1'b1; snax_q_write_i = w; snax_q_data_i = d;
    snax_q_addr_i = a; snax_q_id_i = id;
    while (!hs && cyc < 200) begin
      @(negedge clk_i);
      hs = snax_qready_o;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    if (!hs) chk("req_timeout", 0, 1);
    snax_qvalid_i = 1'b0;
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [4:0] id, input logic [63:0] d);
    exp_req_q.push_back('{1'b0, a - 32'h3c0, 64'h0});
    rd_plan_q.push_back(d);
    exp_rsp_q.push_back('{d[31:0], id});
    exp_rsp_q.push_back('{d[63:32], id});
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_rsp_q.size() != 0 || snax_pvalid_o) && cyc < 200) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    chk("drain_remaining", exp_rsp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(string tag);
    @(negedge clk_i);
    chk({tag, "_qready"}, snax_qready_o, 0);
    chk({tag, "_pvalid"}, snax_pvalid_o, 0);
    chk({tag, "_req_valid"}, csr_req_valid_o, 0);
    chk({tag, "_req_addr"}, csr_req_addr_o, 0);
    chk({tag, "_req_data"}, csr_req_data_o, 0);
    chk({tag, "_rsp_ready"}, csr_rsp_ready_o, 0);
    chk({tag, "_p_data"}, snax_p_data_o, 0);
    chk({tag, "_err"}, err_pulse_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, err_base, cyc;
    bit hs;
    // Reset
    repeat (3) @(posedge clk_i);
    check_idle_outputs("reset");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // T1: two-beat pack, then an address that wraps below the offset
    exp_req_q.push_back('{1'b1, 32'h5, 64'h22222222_11111111});
    req(1, 32'h11111111, 32'h3c5, 0);
    req(1, 32'h22222222, 32'h3c5, 0);
    exp_req_q.push_back('{1'b1, 32'hFFFF_FC40, 64'h0BADBEEF_CAFEF00D});
    req(1, 32'hCAFEF00D, 32'h0, 0);
    req(1, 32'h0BADBEEF, 32'h0, 0);

    // T2: final beat back-pressured for three cycles
    exp_req_q.push_back('{1'b1, 32'h8, 64'h44444444_33333333});
    csr_req_ready_i = 1'b0;
    req(1, 32'h33333333, 32'h3c8, 0);
    snax_qvalid_i = 1'b1; snax_q_write_i = 1'b1;
    snax_q_data_i = 32'h44444444; snax_q_addr_i = 32'h3c8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t2_stall_qready", snax_qready_o, 0);
      chk("t2_stall_valid", csr_req_valid_o, 1);
      @(posedge clk_i);
      #1;
    end
    csr_req_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t2_accept_qready", snax_qready_o, 1);
    @(posedge clk_i);
    #1;
    snax_qvalid_i = 1'b0;

    // T3: read split into two lanes, pready dropped between them
    snax_pready_i = 1'b0;
    expect_read(32'h3c2, 7, 64'hAABBCCDD_00112233);
    req(0, 0, 32'h3c2, 7);
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!snax_pvalid_o && cyc < 50);
    chk("t3_pvalid_seen", snax_pvalid_o, 1);
    @(posedge clk_i);
    #1;
    snax_pready_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    snax_pready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("t3_hold_data", snax_p_data_o, 32'hAABBCCDD);
      chk("t3_hold_id", snax_p_id_o, 7);
      @(posedge clk_i);
      #1;
    end
    snax_pready_i = 1'b1;
    wait_drain();

    // T4: third read stalls on a full ID FIFO until the first word is popped
    rsp_hold = 1'b1;
    expect_read(32'h3d0, 1, 64'h0000000B_0000000A);
    expect_read(32'h3d4, 2, 64'h0000000D_0000000C);
    expect_read(32'h3d8, 3, 64'h0000000F_0000000E);
    req(0, 0, 32'h3d0, 1);
    req(0, 0, 32'h3d4, 2);
    snax_qvalid_i = 1'b1; snax_q_write_i = 1'b0;
    snax_q_addr_i = 32'h3d8; snax_q_id_i = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t4_stall_qready", snax_qready_o, 0);
      chk("t4_stall_req_valid", csr_req_valid_o, 0);
      @(posedge clk_i);
      #1;
    end
    base = rsp_seen;
    rsp_hold = 1'b0;
    hs = 0;
    cyc = 0;
    while (!hs && cyc < 100) begin
      @(negedge clk_i);
      if (snax_qready_o) begin
        hs = 1;
        chk("t4_lanes_before_accept", rsp_seen - base, 2);
      end
      @(posedge clk_i);
      #1;
      cyc++;
    end
    chk("t4_accept", hs, 1);
    snax_qvalid_i = 1'b0;
    wait_drain();

    // T5: address change restarts packing with an error pulse
    err_base = err_seen;
    exp_req_q.push_back('{1'b1, 32'h4, 64'h77777777_66666666});
    req(1, 32'h55555555, 32'h3c1, 0);
    req(1, 32'h66666666, 32'h3c4, 0);
    req(1, 32'h77777777, 32'h3c4, 0);
    err_exp++;
    @(negedge clk_i);
    chk("t5_err_pulses", err_seen - err_base, 1);
    @(posedge clk_i);
    #1;

    // T5b: read during a partial write discards it; next write packs cleanly
    err_base = err_seen;
    expect_read(32'h3c0, 4, 64'h12345678_9ABCDEF0);
    req(1, 32'h99999999, 32'h3c0, 0);
    req(0, 0, 32'h3c0, 4);
    err_exp++;
    wait_drain();
    exp_req_q.push_back('{1'b1, 32'hC, 64'hBBBBBBBB_AAAAAAAA});
    req(1, 32'hAAAAAAAA, 32'h3cc, 0);
    req(1, 32'hBBBBBBBB, 32'h3cc, 0);
    chk("t5b_err_pulses", err_seen - err_base, 1);

    // T6: reset after one beat drops the partial word
    req(1, 32'hDEADBEEF, 32'h3c6, 0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    check_idle_outputs("midreset");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    exp_req_q.push_back('{1'b1, 32'h6, 64'h89ABCDEF_01234567});
    req(1, 32'h01234567, 32'h3c6, 0);
    req(1, 32'h89ABCDEF, 32'h3c6, 0);

    repeat (5) @(posedge clk_i);
    #1;
    chk("end_req_queue", exp_req_q.size(), 0);
    chk("end_rsp_queue", exp_rsp_q.size(), 0);
    chk("end_err_count", err_seen, err_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snax_csr_wide_bridge.md
Name: snax_csr_wide_bridge

Overview:
Bridges the 32-bit SNAX accelerator request/response channel to a parametrisable-width CSR bus, typically 64-bit or wider, of a CGRA-class accelerator.
- Packs multi-beat 32-bit writes into one wide CSR write.
- Splits wide CSR read data into consecutive 32-bit SNAX responses.
- Tracks outstanding read IDs in a small FIFO.
- Sits between the Snitch accelerator port and the accelerator CSR manager.

Parameters:
CsrDataWidth, 64, CSR data width; multiple of 32, minimum 32.
NumBeats, CsrDataWidth/32, derived; 32-bit beats per CSR word.
CsrAddrOffset, 32'h3c0, subtracted from the SNAX address to form the CSR address.
IdWidth, 5, SNAX request/response ID width.
RdFifoDepth, 2, maximum outstanding reads; power of 2, minimum 1.

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
snax_qvalid_i  in  1  request valid
snax_qready_o  out  1  request ready
snax_q_write_i  in  1  1 = write beat, 0 = read
snax_q_data_i  in  32  write data beat (data_arga)
snax_q_addr_i  in  32  SNAX CSR address (data_argb)
snax_q_id_i  in  IdWidth  request ID
snax_pvalid_o  out  1  response valid
snax_pready_i  in  1  response ready
snax_p_data_o  out  32  response data lane
snax_p_id_o  out  IdWidth  response ID
snax_p_error_o  out  1  response error (always 0)
csr_req_valid_o  out  1  CSR request valid
csr_req_ready_i  in  1  CSR request ready
csr_req_write_o  out  1  CSR write enable
csr_req_addr_o  out  32  snax_q_addr_i - CsrAddrOffset, modulo 2^32
csr_req_data_o  out  CsrDataWidth  packed write data
csr_rsp_valid_i  in  1  CSR read response valid (reads only)
csr_rsp_ready_o  out  1  CSR response ready
csr_rsp_data_i  in  CsrDataWidth  CSR read data
err_pulse_o  out  1  one-cycle pulse when a partial write is discarded

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, pack buffer 0, FIFO empty, serializer empty.
- Request FSM states: IDLE, COLLECT, ISSUE.
- Non-final write beat (beat count < NumBeats-1):
  - qready=1 combinationally; no CSR request.
  - Data stored in lane[count]; lane 0 = bits [31:0].
  - Address latched on beat 0; count increments; IDLE->COLLECT.
- Final write beat (count == NumBeats-1, or the first beat when NumBeats==1):
  - csr_req_valid_o=1, write=1, data = {beat, lanes[NumBeats-2:0]}, addr from the current beat.
  - qready_o = csr_req_ready_i in the same cycle (zero-latency pass-through).
  - On handshake: count cleared, ->IDLE.
  - No SNAX response is generated for writes.
- Address mismatch: a write beat in COLLECT whose address differs from the latched address:
  - Partial word discarded; err_pulse_o=1 for 1 cycle.
  - The beat is accepted as beat 0 of a new word.
- Read request:
  - csr_req_valid_o=1, write=0, data=0.
  - qready_o = csr_req_ready_i AND FIFO not full.
  - On handshake, snax_q_id_i is pushed into the read-ID FIFO.
  - If it arrives in COLLECT: partial write discarded, err_pulse_o=1 in the handshake cycle, ->IDLE.
  - While the FIFO is full, the read stalls; csr_req_valid_o stays 0 until space frees.
- Response serializer:
  - csr_rsp_ready_o=1 only when the serializer is empty.
  - On CSR response handshake, csr_rsp_data_i is captured and the FIFO head ID is attached.
  - Sends NumBeats SNAX responses, lane 0 first, one per pready handshake.
  - pvalid/data/id stable while pready=0.
  - On the last lane handshake, the FIFO entry is popped and the serializer becomes empty.
  - Next CSR response is accepted the following cycle at the earliest.
- Simultaneous events: FIFO push and pop in the same cycle are allowed; occupancy is unchanged.
- A CSR response with the FIFO empty is a protocol violation; an assertion fires.
- Reset mid-operation: partial words, FIFO contents and serializer state are dropped immediately; no outputs glitch after reset release.
- Width rules:
  - Address subtraction wraps modulo 2^32.
  - FIFO pointers carry one extra bit for full/empty distinction.

Test Plan:
1. NumBeats=2: write 0x11111111 then 0x22222222 @0x3c5 -> one CSR write, data 0x2222222211111111, addr 0x5; no SNAX response.
2. Final beat with csr_req_ready_i low for 3 cycles -> qready_o low 3 cycles, request held stable, accepted on cycle 4.
3. Read @0x3c2, id 7; CSR returns 0xAABBCCDD_00112233 -> responses 0x00112233 then 0xAABBCCDD, both id 7; hold pready low 2 cycles mid-sequence -> data held.
4. Three back-to-back reads (RdFifoDepth=2), CSR responses delayed -> third read stalls until the first serializer pop; IDs returned in order.
5. Write beat @0x3c1, then write beat @0x3c4 -> err_pulse_o one cycle; second beat becomes beat 0; subsequent beat completes write at addr 0x4.
6. Reset asserted after first write beat -> on release, a fresh two-beat write packs correctly with no stale lane data.
